// File: rtl/lc2k_pkg.sv
// Shared definitions for the LC2K register file and writeback stage.
package lc2k_pkg;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 32;

  localparam logic WB_SEL_ALU    = 1'b0;
  localparam logic WB_SEL_MEM    = 1'b1;
  localparam logic DEST_SEL_DEST = 1'b0;
  localparam logic DEST_SEL_REGB = 1'b1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } runState_e;
endpackage

// File: rtl/lc2k_regfile_wb_if.sv
// Operand-read and writeback bus between the pipeline and the register file.
interface lc2k_regfile_wb_if;
  import lc2k_pkg::*;

  logic [ADDR_W-1:0] regA_addr;
  logic [ADDR_W-1:0] regB_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] memData;
  logic              CONTROL_wbSel;
  logic              CONTROL_destSel;
  logic              CONTROL_regWrite;
  logic              halt;
  logic [DATA_W-1:0] regAvalue;
  logic [DATA_W-1:0] regBvalue;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              halted;
  logic [31:0]       retire_count;

  modport master (
    output regA_addr, regB_addr, dest_addr, aluResult, memData,
           CONTROL_wbSel, CONTROL_destSel, CONTROL_regWrite, halt,
    input  regAvalue, regBvalue, wb_valid, wb_addr, wb_data, halted, retire_count
  );

  modport slave (
    input  regA_addr, regB_addr, dest_addr, aluResult, memData,
           CONTROL_wbSel, CONTROL_destSel, CONTROL_regWrite, halt,
    output regAvalue, regBvalue, wb_valid, wb_addr, wb_data, halted, retire_count
  );
endinterface

// File: rtl/lc2k_regfile_core.sv
// Register storage with one write port and two registered, write-first bypassed read ports.
module lc2k_regfile_core
  import lc2k_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddrA,
  input  logic [ADDR_W-1:0] rAddrB,
  output logic [DATA_W-1:0] rDataA,
  output logic [DATA_W-1:0] rDataB
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Entry 0 exists only to keep indexing uniform; we is never raised for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      rDataA <= '0;
      rDataB <= '0;
    end else begin
      if (we) begin
        mem[wAddr] <= wData;
      end
      if (rAddrA == '0)
        rDataA <= '0;
      else if (we && (wAddr == rAddrA))
        rDataA <= wData;
      else
        rDataA <= mem[rAddrA];
      if (rAddrB == '0)
        rDataB <= '0;
      else if (we && (wAddr == rAddrB))
        rDataB <= wData;
      else
        rDataB <= mem[rAddrB];
    end
  end

endmodule

// File: rtl/lc2k_regfile_wb.sv
// LC2K register file top: writeback source/destination selection, halt FSM,
// committed-write reporting and retire counter around the storage core.
module lc2k_regfile_wb
  import lc2k_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  lc2k_regfile_wb_if.slave bus
);

  runState_e         state;
  logic              haltedReg;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              commit;
  logic              wbValid;
  logic [ADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0] wbData;
  logic [31:0]       retireCount;
  logic [DATA_W-1:0] rDataA;
  logic [DATA_W-1:0] rDataB;

  assign wAddr = (bus.CONTROL_destSel == DEST_SEL_REGB) ? bus.regB_addr : bus.dest_addr;
  assign wData = (bus.CONTROL_wbSel == WB_SEL_MEM) ? bus.memData : bus.aluResult;

  // The retiring halt instruction itself must not write, so halt blocks commit.
  assign commit = (state == RUN) && !bus.halt && bus.CONTROL_regWrite && (wAddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      haltedReg <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.halt) begin
            state     <= HALTED;
            haltedReg <= 1'b1;
          end
        end
        HALTED: begin
          state     <= HALTED;
          haltedReg <= 1'b1;
        end
        default: begin
          state     <= RUN;
          haltedReg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid     <= 1'b0;
      wbAddr      <= '0;
      wbData      <= '0;
      retireCount <= '0;
    end else begin
      wbValid <= commit;
      if (commit) begin
        wbAddr      <= wAddr;
        wbData      <= wData;
        retireCount <= retireCount + 32'd1;
      end
    end
  end

  lc2k_regfile_core core (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit),
    .wAddr  (wAddr),
    .wData  (wData),
    .rAddrA (bus.regA_addr),
    .rAddrB (bus.regB_addr),
    .rDataA (rDataA),
    .rDataB (rDataB)
  );

  assign bus.regAvalue    = rDataA;
  assign bus.regBvalue    = rDataB;
  assign bus.wb_valid     = wbValid;
  assign bus.wb_addr      = wbAddr;
  assign bus.wb_data      = wbData;
  assign bus.halted       = haltedReg;
  assign bus.retire_count = retireCount;

endmodule
